// File: rtl/early_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module   : early_resolve_pkg
// Purpose  : Shared decode types and helpers for the rename-stage early resolver.
// Revision : 1.0
// ============================================================================
package early_resolve_pkg;

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JAL    = 3'd2,
        OP_LUI    = 3'd3,
        OP_AUIPC  = 3'd4
    } early_op_t;

    // Default-width entry; the top re-declares it at its own WIDTH/TAG_W.
    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  tag;
    } early_entry_t;

    function automatic early_op_t decode_op(
        input logic br,
        input logic jal,
        input logic lui,
        input logic auipc
    );
        if (br)         return OP_BRANCH;
        else if (jal)   return OP_JAL;
        else if (lui)   return OP_LUI;
        else if (auipc) return OP_AUIPC;
        else            return OP_NONE;
    endfunction

    function automatic logic op_has_result(input early_op_t op);
        return (op == OP_JAL) || (op == OP_LUI) || (op == OP_AUIPC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/early_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : early_result_fifo
// Purpose  : Circular buffer of early results awaiting a CDB slot.
// Revision : 1.0
// ============================================================================
module early_result_fifo
    import early_resolve_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         ENTRY_T = early_entry_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  ENTRY_T                 din,
    output ENTRY_T                 dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned c_addr_w = $clog2(DEPTH);

    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_count;
    ENTRY_T              r_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign full      = (r_count == (c_addr_w + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    // Head reads as zero when empty so the CDB bus is quiet after reset/flush.
    assign dout      = empty ? ENTRY_T'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/early_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : early_resolve_unit
// Purpose  : Rename-stage JAL/LUI/AUIPC resolution, fetch redirect and CDB queue.
//            Optional misdirect counter when EARLY_RESOLVE_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module early_resolve_unit
    import early_resolve_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PC_STEP = 1,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned DEPTH   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             stall,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    input  logic [WIDTH-1:0] pred_pc,
    input  logic [TAG_W-1:0] rob_tag,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_lui,
    input  logic             is_auipc,
    input  logic             redirect_en,
    input  logic             flush,
    output logic [WIDTH-1:0] target_addr,
    output logic [WIDTH-1:0] seq_pc,
    output logic             misdirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             btb_we,
    output logic [WIDTH-1:0] btb_pc,
    output logic [WIDTH-1:0] btb_target,
`ifdef EARLY_RESOLVE_PERF_EN
    output logic [31:0]      perf_misdirect_cnt,
`endif
    output logic             cdb_req,
    input  logic             cdb_grant,
    output logic [WIDTH-1:0] cdb_result,
    output logic [TAG_W-1:0] cdb_tag
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
    } entry_t;

    early_op_t             w_op;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_jal;
    logic [WIDTH-1:0]      w_target;
    logic [WIDTH-1:0]      w_seq;
    entry_t                w_entry;
    entry_t                w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  r_misdirect;
    logic                  r_btb_we;
    logic [WIDTH-1:0]      r_redirect_pc;
    logic [WIDTH-1:0]      r_btb_pc;
    logic [WIDTH-1:0]      r_btb_target;

    assign w_op        = decode_op(is_branch, is_jal, is_lui, is_auipc);
    assign w_accept    = in_valid & ~stall & ~flush;
    assign w_target    = pc + imm_ext;
    assign w_seq       = pc + WIDTH'(PC_STEP);
    assign w_push      = w_accept & op_has_result(w_op);
    assign w_jal       = w_accept & (w_op == OP_JAL);
    assign w_pop       = cdb_grant & ~w_empty & ~flush;

    assign target_addr = w_target;
    assign seq_pc      = w_seq;
    assign stall       = w_full;
    assign cdb_req     = (w_count != '0);
    assign cdb_result  = w_head.result;
    assign cdb_tag     = w_head.tag;
    assign misdirect   = r_misdirect;
    assign btb_we      = r_btb_we;
    assign redirect_pc = r_redirect_pc;
    assign btb_pc      = r_btb_pc;
    assign btb_target  = r_btb_target;

    always_comb begin
        w_entry     = '0;
        w_entry.tag = rob_tag;
        case (w_op)
            OP_JAL:   w_entry.result = w_seq;
            OP_LUI:   w_entry.result = imm_ext;
            OP_AUIPC: w_entry.result = w_target;
            default:  w_entry.result = '0;
        endcase
    end

    early_result_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_entry),
        .dout    (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Flush suppresses both pulses because w_jal already requires ~flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_misdirect   <= 1'b0;
            r_btb_we      <= 1'b0;
            r_redirect_pc <= '0;
            r_btb_pc      <= '0;
            r_btb_target  <= '0;
        end else begin
            r_misdirect <= w_jal & redirect_en & (w_target != pred_pc);
            r_btb_we    <= w_jal;
            if (w_jal) begin
                r_redirect_pc <= w_target;
                r_btb_pc      <= pc;
                r_btb_target  <= w_target;
            end
        end
    end

`ifdef EARLY_RESOLVE_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          r_perf_cnt <= '0;
        else if (r_misdirect && ~&r_perf_cnt)  r_perf_cnt <= r_perf_cnt + 1'b1;
    end

    assign perf_misdirect_cnt = r_perf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_early_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_early_resolve_unit
// Purpose  : Directed and randomized self-checking bench for early_resolve_unit.
// Revision : 1.0
// ============================================================================
module tb_early_resolve_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, stall;
    logic [31:0] pc, imm_ext, pred_pc;
    logic [3:0]  rob_tag;
    logic        is_branch, is_jal, is_lui, is_auipc, redirect_en, flush;
    logic [31:0] target_addr, seq_pc, redirect_pc, btb_pc, btb_target, cdb_result;
    logic        misdirect, btb_we, cdb_req, cdb_grant;
    logic [3:0]  cdb_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    early_resolve_unit dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
        .pc(pc), .imm_ext(imm_ext), .pred_pc(pred_pc), .rob_tag(rob_tag),
        .is_branch(is_branch), .is_jal(is_jal), .is_lui(is_lui), .is_auipc(is_auipc),
        .redirect_en(redirect_en), .flush(flush), .target_addr(target_addr),
        .seq_pc(seq_pc), .misdirect(misdirect), .redirect_pc(redirect_pc),
        .btb_we(btb_we), .btb_pc(btb_pc), .btb_target(btb_target),
        .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_result(cdb_result), .cdb_tag(cdb_tag)
    );

    task automatic idle();
        in_valid = 0; pc = 0; imm_ext = 0; pred_pc = 0; rob_tag = 0;
        is_branch = 0; is_jal = 0; is_lui = 0; is_auipc = 0;
        redirect_en = 0; flush = 0; cdb_grant = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && cdb_req; i++) begin cdb_grant = 1; step(); end
        cdb_grant = 0;
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: cdb_req=%b required 0", cdb_req); end
    endtask

    task automatic test_reset();
        idle(); reset_n = 0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if ({stall, misdirect, btb_we, cdb_req} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b required 0000", {stall, misdirect, btb_we, cdb_req}); end
        n_checks++; if ({cdb_result, cdb_tag} !== 36'h0) begin n_fail++; $display("FAIL reset_cdb: got %h/%h required 0/0", cdb_result, cdb_tag); end
        n_checks++; if ({redirect_pc, btb_pc, btb_target} !== 96'h0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h required 0", redirect_pc, btb_pc, btb_target); end
        reset_n = 1; step();
        n_checks++; if (cdb_req !== 1'b0) begin n_fail++; $display("FAIL reset_release: cdb_req=%b required 0", cdb_req); end
    endtask

    task automatic test_jal();
        logic [31:0] preds [3];
        logic        ens   [3];
        preds = '{32'h120, 32'h101, 32'h101};
        ens   = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            idle(); in_valid = 1; is_jal = 1; pc = 32'h100; imm_ext = 32'h20;
            pred_pc = preds[k]; redirect_en = ens[k]; rob_tag = 4'(k + 1);
            #1;
            n_checks++; if (target_addr !== 32'h120 || seq_pc !== 32'h101) begin n_fail++; $display("FAIL jal_comb[%0d]: target=%h seq=%h required 120/101", k, target_addr, seq_pc); end
            step(); idle();
            n_checks++; if (btb_we !== 1'b1 || btb_pc !== 32'h100 || btb_target !== 32'h120) begin n_fail++; $display("FAIL jal_btb[%0d]: we=%b pc=%h tgt=%h required 1/100/120", k, btb_we, btb_pc, btb_target); end
            n_checks++; if (misdirect !== (k == 1)) begin n_fail++; $display("FAIL jal_misdirect[%0d]: got %b required %b", k, misdirect, k == 1); end
            if (k == 1) begin
                n_checks++; if (redirect_pc !== 32'h120) begin n_fail++; $display("FAIL jal_redirect_pc: got %h required 120", redirect_pc); end
            end
            n_checks++; if (cdb_req !== 1'b1 || cdb_result !== 32'h101 || cdb_tag !== 4'(k + 1)) begin n_fail++; $display("FAIL jal_cdb[%0d]: req=%b res=%h tag=%h required 1/101/%h", k, cdb_req, cdb_result, cdb_tag, k + 1); end
            step();
            n_checks++; if (btb_we !== 1'b0 || misdirect !== 1'b0) begin n_fail++; $display("FAIL jal_pulse_len[%0d]: we=%b mis=%b required 0/0", k, btb_we, misdirect); end
            drain();
        end
    endtask

    task automatic test_fifo_stall();
        idle(); in_valid = 1; is_lui = 1; imm_ext = 32'hABCDE000; rob_tag = 4'd3; step();
        idle(); in_valid = 1; is_auipc = 1; pc = 32'h40; imm_ext = 32'h1000; rob_tag = 4'd4; step();
        idle();
        n_checks++; if (stall !== 1'b1 || cdb_req !== 1'b1) begin n_fail++; $display("FAIL fifo_full: stall=%b req=%b required 1/1", stall, cdb_req); end
        in_valid = 1; is_lui = 1; imm_ext = 32'hDEAD0000; rob_tag = 4'd9; step(); idle();
        n_checks++; if (cdb_tag !== 4'd3 || cdb_result !== 32'hABCDE000) begin n_fail++; $display("FAIL fifo_head0: tag=%h res=%h required 3/abcde000", cdb_tag, cdb_result); end
        cdb_grant = 1; step();
        n_checks++; if (cdb_tag !== 4'd4 || cdb_result !== 32'h1040 || stall !== 1'b0) begin n_fail++; $display("FAIL fifo_head1: tag=%h res=%h stall=%b required 4/1040/0", cdb_tag, cdb_result, stall); end
        step(); cdb_grant = 0;
        n_checks++; if (cdb_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL fifo_empty: req=%b stall=%b required 0/0", cdb_req, stall); end
        cdb_grant = 1; step(); cdb_grant = 0;
        n_checks++; if (cdb_req !== 1'b0 || cdb_result !== 32'h0) begin n_fail++; $display("FAIL fifo_grant_empty: req=%b res=%h required 0/0", cdb_req, cdb_result); end
    endtask

    task automatic test_branch_wrap();
        idle(); in_valid = 1; is_branch = 1; is_jal = 1; pc = 32'h10; imm_ext = 32'h8; redirect_en = 1; #1;
        n_checks++; if (target_addr !== 32'h18) begin n_fail++; $display("FAIL branch_target: got %h required 18", target_addr); end
        step(); idle();
        n_checks++; if (btb_we !== 1'b0 || cdb_req !== 1'b0 || misdirect !== 1'b0) begin n_fail++; $display("FAIL branch_priority: we=%b req=%b mis=%b required 0/0/0", btb_we, cdb_req, misdirect); end
        pc = 32'hFFFFFFFF; imm_ext = 32'h2; #1;
        n_checks++; if (target_addr !== 32'h1 || seq_pc !== 32'h0) begin n_fail++; $display("FAIL wrap: target=%h seq=%h required 1/0", target_addr, seq_pc); end
    endtask

    task automatic test_flush();
        idle(); in_valid = 1; is_lui = 1; imm_ext = 32'h5; rob_tag = 4'd1; step();
        rob_tag = 4'd2; step(); idle();
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_prefill: stall=%b required 1", stall); end
        stall_release_jal: begin
            in_valid = 1; is_jal = 1; pc = 32'h200; imm_ext = 32'h40; pred_pc = 32'h0;
            redirect_en = 1; cdb_grant = 1; flush = 1;
        end
        step(); idle();
        n_checks++; if ({cdb_req, stall, misdirect, btb_we} !== 4'b0) begin n_fail++; $display("FAIL flush: req/stall/mis/we=%b required 0000", {cdb_req, stall, misdirect, btb_we}); end
    endtask

    task automatic test_async_reset();
        idle(); in_valid = 1; is_jal = 1; pc = 32'h300; imm_ext = 32'h4; pred_pc = 32'h0; redirect_en = 1; step(); idle();
        n_checks++; if (cdb_req !== 1'b1 || btb_we !== 1'b1 || misdirect !== 1'b1) begin n_fail++; $display("FAIL areset_pre: req=%b we=%b mis=%b required 1/1/1", cdb_req, btb_we, misdirect); end
        #2 reset_n = 0; #1;
        n_checks++; if ({cdb_req, stall, misdirect, btb_we} !== 4'b0) begin n_fail++; $display("FAIL areset_now: req/stall/mis/we=%b required 0000", {cdb_req, stall, misdirect, btb_we}); end
        step(); reset_n = 1; step(); step();
        n_checks++; if ({cdb_req, stall, misdirect, btb_we} !== 4'b0) begin n_fail++; $display("FAIL areset_after: req/stall/mis/we=%b required 0000", {cdb_req, stall, misdirect, btb_we}); end
    endtask

    typedef struct { logic [31:0] res; logic [3:0] tag; } ent_t;

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic        e_mis, e_we;
        logic [31:0] e_rpc, e_bpc, e_btg, tgt;
        idle(); flush = 1; step(); idle();
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            {is_branch, is_jal, is_lui, is_auipc} = 4'($urandom);
            pc          = $urandom; imm_ext = $urandom; rob_tag = 4'($urandom);
            tgt         = pc + imm_ext;
            pred_pc     = $urandom_range(0, 1) ? tgt : 32'($urandom);
            redirect_en = 1'($urandom);
            cdb_grant   = 1'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            #1;
            n_checks++; if (stall !== (q.size() == 2) || cdb_req !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_state[%0d]: stall=%b req=%b model_size=%0d", n, stall, cdb_req, q.size()); end
            if (q.size() != 0) begin
                n_checks++; if (cdb_result !== q[0].res || cdb_tag !== q[0].tag) begin n_fail++; $display("FAIL rnd_head[%0d]: res=%h tag=%h required %h/%h", n, cdb_result, cdb_tag, q[0].res, q[0].tag); end
            end
            n_checks++; if (target_addr !== tgt || seq_pc !== pc + 32'd1) begin n_fail++; $display("FAIL rnd_comb[%0d]: tgt=%h seq=%h required %h/%h", n, target_addr, seq_pc, tgt, pc + 32'd1); end
            e_mis = 0; e_we = 0;
            if (flush) q.delete();
            else begin
                if (cdb_grant && q.size() != 0) void'(q.pop_front());
                if (in_valid && stall !== 1'b1 && q.size() < 3 && !is_branch && (is_jal || is_lui || is_auipc)) begin
                    e.tag = rob_tag;
                    e.res = is_jal ? pc + 32'd1 : (is_lui ? imm_ext : tgt);
                    if (!(q.size() == 2 && !cdb_grant)) q.push_back(e);
                    if (is_jal) begin
                        e_we = 1; e_bpc = pc; e_btg = tgt; e_rpc = tgt;
                        e_mis = redirect_en && (tgt != pred_pc);
                    end
                end
            end
            step();
            n_checks++; if (btb_we !== e_we || misdirect !== e_mis) begin n_fail++; $display("FAIL rnd_pulse[%0d]: we=%b mis=%b required %b/%b", n, btb_we, misdirect, e_we, e_mis); end
            if (e_we) begin
                n_checks++; if (btb_pc !== e_bpc || btb_target !== e_btg || redirect_pc !== e_rpc) begin n_fail++; $display("FAIL rnd_btb[%0d]: pc=%h tgt=%h rpc=%h required %h/%h/%h", n, btb_pc, btb_target, redirect_pc, e_bpc, e_btg, e_rpc); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_jal();
        test_fifo_stall();
        test_branch_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
